// File: rtl/deck_shuffler.sv
// deck_shuffler
// Holds a shoe of DECKS*CARDS card codes in a register array. On start it
// rebuilds the shoe as identity (one entry per cycle) and then permutes it in
// place with a Fisher-Yates loop. Each swap index comes from a 16-bit Galois
// LFSR.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   start      request a rebuild-and-shuffle (accepted only when idle)
//   seed_load  load 'seed' into the LFSR (accepted only when idle)
//   seed       LFSR seed; zero is replaced by LFSR_SEED
//   rd_addr    shoe index to read
//   rd_data    card code at rd_addr (0 when rd_addr is past the shoe)
//   busy       high while rebuilding or swapping
//   done       one-cycle pulse when a shuffle completes
module deck_shuffler #(
  parameter int          CARDS     = 52,
  parameter int          DECKS     = 1,
  parameter int          ADDR_W    = 6,
  parameter int          CARD_W    = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CARD_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam int                N        = CARDS * DECKS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  // One extra bit so the comparisons and modulo still work when
  // N or CARDS equals 2^ADDR_W.
  localparam logic [ADDR_W:0]   N_W      = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]   CARDS_W  = (ADDR_W + 1)'(CARDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_SWAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CARD_W-1:0]   deck_q [N];
  logic [CARD_W-1:0]   deck_d [N];

  logic [15:0]         lfsr_next;
  logic [ADDR_W-1:0]   swap_j;

  // Identity card code for a shoe position: position mod CARDS.
  function automatic logic [CARD_W-1:0] card_code(input logic [ADDR_W-1:0] idx);
    card_code = CARD_W'({1'b0, idx} % CARDS_W);
  endfunction

  // Galois right-shift LFSR with tap mask 0xB400.
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // Swap partner j = lfsr % (i+1). This is always below i+1, so it fits ADDR_W bits.
  assign swap_j = ADDR_W'(lfsr_q % (16'(idx_q) + 16'd1));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    deck_d  = deck_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
        end
        if (start) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        deck_d[idx_q] = card_code(idx_q);
        if (idx_q == LAST_IDX) begin
          // A one-card shoe has nothing to swap.
          if (N == 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SWAP;
            idx_d   = LAST_IDX;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SWAP: begin
        // When j == i, both writes store the same value, so the swap does nothing.
        deck_d[swap_j] = deck_q[idx_q];
        deck_d[idx_q]  = deck_q[swap_j];
        lfsr_d         = lfsr_next;
        idx_d          = idx_q - 1'b1;
        if (idx_q == ADDR_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      for (int k = 0; k < N; k++) begin
        deck_q[k] <= card_code(ADDR_W'(k));
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      deck_q  <= deck_d;
    end
  end

  // Asynchronous read port. Out-of-range addresses return 0.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < N_W) begin
      rd_data = deck_q[rd_addr];
    end
  end

  assign busy = (state_q == S_INIT) || (state_q == S_SWAP);
  assign done = (state_q == S_DONE);

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
Sequential, parametrised card-deck shuffler for the BlackJack datapath. It holds a shoe of DECKS×CARDS card codes in a register array, rebuilds it as identity on command, and permutes it in place with a seeded 16-bit LFSR driving a Fisher-Yates swap loop. It replaces the combinational next-address permutation with a deterministic, bounded-latency shuffle. The dealer FSM reads cards through an asynchronous read port once the shuffle completes.

Parameters:
CARDS, 52, cards per deck; card codes are 0..CARDS-1.
DECKS, 1, decks in the shoe; N = CARDS*DECKS.
ADDR_W, 6, shoe index width; must satisfy 2^ADDR_W >= N.
CARD_W, 6, card code width; must satisfy 2^CARD_W >= CARDS.
LFSR_SEED, 16'hACE1, LFSR reset value and substitute for a zero seed.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a rebuild-and-shuffle; sampled only in IDLE.
seed_load  in  1  load seed into the LFSR; sampled only in IDLE.
seed  in  16  seed value used with seed_load.
rd_addr  in  ADDR_W  shoe index to read.
rd_data  out  CARD_W  card code at rd_addr.
busy  out  1  high during INIT and SWAP.
done  out  1  one-cycle pulse when the shuffle completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0.
  - lfsr=LFSR_SEED, i=0.
  - deck[k] = k mod CARDS for all k < N.
- rd_data = deck[rd_addr] combinationally, in every state. rd_addr >= N returns 0. Contents are a valid permutation only while busy=0.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400.
  - next = lfsr[0] ? (lfsr>>1) ^ 16'hB400 : lfsr>>1.
  - Advances only in SWAP cycles.
- IDLE:
  - seed_load=1 → lfsr <= (seed==0) ? LFSR_SEED : seed.
  - start=1 → go to INIT with k=0.
  - seed_load and start in the same cycle: the seed is loaded and the shuffle starts. The first SWAP uses the new seed.
- INIT: one write per cycle, deck[k] <= k mod CARDS. Runs N cycles (k = 0..N-1), then SWAP with i=N-1.
- SWAP: one swap per cycle.
  - j = lfsr % (i+1), a combinational modulo on the 16-bit current value.
  - Swap deck[i] and deck[j]; j==i is a no-op.
  - lfsr <= next; i <= i-1.
  - The i==1 cycle is the last swap; then go to DONE. N-1 cycles total.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy is high in INIT and SWAP, so for exactly 2N-1 cycles after start is accepted.
- start or seed_load while busy, or in DONE, is ignored and not queued.
- The LFSR state carries over between shuffles. Back-to-back shuffles without a reseed therefore give different decks.
- Reset mid-INIT or mid-SWAP aborts at once and restores the full reset state, including the identity deck and LFSR_SEED. No done pulse is produced.
- N==1: SWAP is skipped. INIT runs 1 cycle, then DONE.
- Width rules:
  - i and j are ADDR_W bits; j < i+1 <= N always.
  - Card codes are written as k mod CARDS, zero-extended to CARD_W.

Test Plan:
- Reset, then read rd_addr=0..51 → rd_data=0..51, busy=0, done=0. rd_addr=60 → 0.
- Default seed, pulse start → busy high for exactly 103 cycles, then done high for 1 cycle. Deck holds each of 0..51 exactly once and matches a bit-accurate reference model (identity, Galois 0xB400 LFSR, j=lfsr%(i+1), i=51..1).
- seed_load with seed=16'h1234, then start; repeat the same sequence → both decks are identical. A third start without a reseed gives a different deck. seed_load with seed=0 gives the same deck as LFSR_SEED.
- DECKS=2 (ADDR_W=7) → busy for 207 cycles, each code 0..51 appears exactly twice.
- Assert rst_n=0 midway through SWAP (e.g. 60 cycles after start) → busy=0 and done=0 immediately, deck is identity, next shuffle with no seed_load matches the post-reset default deck.
- Pulse start and seed_load during INIT → no restart, LFSR unchanged, completion time unchanged, single done pulse.
